led_pattern_engine: RTL and testbench
=====================================

# led_pattern_engine

Parametrised LED pattern generator for the board-level demo top. It drives a WIDTH-bit LED bar with a rotate, bounce, fill/drain or hold pattern. Each pattern step is gated by an enable input and slowed by a programmable prescaler. With mode=ROT, dir=0 and div=0, the behaviour equals a plain rotate-left-on-button LED ring.

## Interface
- WIDTH, default 8: LED count; legal range WIDTH >= 2.
- DIV_W, default 4: prescaler divisor width; legal range DIV_W >= 1.

- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- en  input  1  advance enable; the prescaler counts only while en=1.
- mode  input  2  pattern select: 00 ROT, 01 BOUNCE, 10 FILL, 11 HOLD.
- dir  input  1  direction: 0 = towards MSB (left), 1 = towards LSB (right). Used by ROT, and sampled into the bounce direction on load.
- div  input  DIV_W  step every div+1 enabled cycles.
- load  input  1  synchronous load of load_val; has priority over stepping.
- load_val  input  WIDTH  pattern to load.
- led  output  WIDTH  current pattern (registered).
- step  output  1  registered one-cycle pulse, high in the cycle after each pattern step.

## Operation
- Internal state:
  - cnt[DIV_W-1:0], the prescaler count.
  - bdir, the bounce direction (0 = left).
  - phase, the fill phase (0 = filling, 1 = draining).
- Reset values: led = 1 (bit 0 set only), cnt = 0, bdir = 0, phase = 0, step = 0.
- tick is combinational: tick = en & (cnt >= div). The >= compare makes a mid-count reduction of div tick immediately.
- Prescaler:
  - en=0: cnt holds.
  - en=1 with tick: cnt <= 0.
  - en=1 without tick: cnt <= cnt+1.
- load=1: led <= load_val, cnt <= 0, bdir <= dir, phase <= 0, step <= 0. No step occurs that cycle, whatever the value of en.
- Otherwise, on tick:
  - step <= 1.
  - led updates by mode, as listed below.
- Otherwise: step <= 0 and led holds.
- ROT:
  - dir=0: led <= {led[WIDTH-2:0], led[WIDTH-1]}.
  - dir=1: led <= {led[0], led[WIDTH-1:1]}.
- BOUNCE:
  - bdir=0 and led[WIDTH-1]=1: led <= led>>1, bdir <= 1.
  - bdir=0, otherwise: led <= led<<1.
  - bdir=1 and led[0]=1: led <= led<<1, bdir <= 0.
  - bdir=1, otherwise: led <= led>>1.
  - Shifts are logical; bits shifted out are lost. The dir input is ignored except on load.
- FILL (dir ignored):
  - phase=0 and led all ones: led <= led<<1, phase <= 1.
  - phase=0, otherwise: led <= (led<<1)|1.
  - phase=1 and led==0: led <= 1, phase <= 0.
  - phase=1, otherwise: led <= led<<1.
- HOLD: led holds. Ticks and step pulses still occur, and bdir and phase hold.
- Mode or dir changes take effect at the next tick. bdir and phase are never cleared by a mode change.
- led=0 in ROT or BOUNCE stays 0 until a load or reset. This is legal and not an error.

## Timing
- With div=D, en held high and cnt=0 at cycle k, led changes at the rising edge ending cycle k+D. Steps then repeat every D+1 cycles.
- div=0 with en held high: led changes on every clock edge.
- step is high exactly in the cycle in which the new led value is first visible.
- Dropping en mid-count freezes cnt. Counting resumes from the frozen value with no restart.
- rst asserted at any time forces all reset values immediately, with no clock required. Operation resumes at the first rising edge after rst falls, with cnt counting from 0.
- load and tick in the same cycle: load wins and no step pulse is produced.

## Test plan
- Reset and rotate left:
  - Stimulus: assert rst mid-pattern, then release; mode=00, dir=0, div=0, en=1, WIDTH=8.
  - Required: led = 0x01 and step = 0 immediately on rst. After release, led = 0x02, 0x04, …, 0x80, 0x01 on successive edges, with step high every cycle.
- Rotate right:
  - Stimulus: dir=1, div=0, en=1.
  - Required: led = 0x01 → 0x80 → 0x40. Toggling en low for 3 cycles freezes led and step=0 during the gap.
- Bounce:
  - Stimulus: load 0x01 with dir=0, mode=01, div=0, en=1.
  - Required: 0x02, 0x04, …, 0x80, 0x40, …, 0x01, 0x02. The period is 14 steps.
- Fill/drain:
  - Stimulus: load 0x01, mode=10, div=0, en=1.
  - Required: 0x03, 0x07, …, 0xFF, 0xFE, 0xFC, …, 0x80, 0x00, 0x01. The period is 16 steps.
- Prescaler:
  - Stimulus: div=3, en=1.
  - Required: one step every 4 cycles. Changing div to 1 while cnt=2 gives a step on the next edge.
- Load priority and HOLD:
  - load=1 with load_val=0xA5 on a tick cycle: led = 0xA5 and step = 0.
  - mode=11: led stays 0xA5 while step still pulses at the prescaler rate.

Source files
------------

// File: rtl/led_pattern_engine.sv
// LED pattern generator: rotate, bounce, fill/drain or hold on a WIDTH-bit bar.
// Each pattern step is gated by en and slowed by a div+1 prescaler.
module led_pattern_engine #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] led,
  output logic             step
);

  localparam logic [1:0] ModeRot    = 2'b00;
  localparam logic [1:0] ModeBounce = 2'b01;
  localparam logic [1:0] ModeFill   = 2'b10;
  localparam logic [1:0] ModeHold   = 2'b11;

  logic [DIV_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_led;
  logic             r_bdir;
  logic             r_phase;
  logic             r_step;

  logic             w_tick;
  logic [WIDTH-1:0] w_led_nxt;
  logic             w_bdir_nxt;
  logic             w_phase_nxt;

  // >= rather than == so that lowering div mid-count ticks at once.
  assign w_tick = en & (r_cnt >= div);

  // Next pattern value and bounce/fill state for a tick in the current mode.
  always_comb begin
    w_led_nxt   = r_led;
    w_bdir_nxt  = r_bdir;
    w_phase_nxt = r_phase;
    unique case (mode)
      ModeRot: begin
        if (!dir) w_led_nxt = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
        else      w_led_nxt = {r_led[0], r_led[WIDTH-1:1]};
      end
      ModeBounce: begin
        if (!r_bdir) begin
          if (r_led[WIDTH-1]) begin
            w_led_nxt  = r_led >> 1;
            w_bdir_nxt = 1'b1;
          end else begin
            w_led_nxt  = r_led << 1;
          end
        end else begin
          if (r_led[0]) begin
            w_led_nxt  = r_led << 1;
            w_bdir_nxt = 1'b0;
          end else begin
            w_led_nxt  = r_led >> 1;
          end
        end
      end
      ModeFill: begin
        if (!r_phase) begin
          if (&r_led) begin
            w_led_nxt   = r_led << 1;
            w_phase_nxt = 1'b1;
          end else begin
            w_led_nxt   = (r_led << 1) | WIDTH'(1);
          end
        end else begin
          if (r_led == '0) begin
            w_led_nxt   = WIDTH'(1);
            w_phase_nxt = 1'b0;
          end else begin
            w_led_nxt   = r_led << 1;
          end
        end
      end
      ModeHold: begin
        w_led_nxt = r_led;
      end
      default: begin
        w_led_nxt = r_led;
      end
    endcase
  end

  // Prescaler counter; load restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= '0;
    end else if (en) begin
      if (w_tick) r_cnt <= '0;
      else        r_cnt <= r_cnt + DIV_W'(1);
    end
  end

  // Pattern state and step pulse; load beats a same-cycle tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led   <= WIDTH'(1);
      r_bdir  <= 1'b0;
      r_phase <= 1'b0;
      r_step  <= 1'b0;
    end else if (load) begin
      r_led   <= load_val;
      r_bdir  <= dir;
      r_phase <= 1'b0;
      r_step  <= 1'b0;
    end else if (w_tick) begin
      r_led   <= w_led_nxt;
      r_bdir  <= w_bdir_nxt;
      r_phase <= w_phase_nxt;
      r_step  <= 1'b1;
    end else begin
      r_step  <= 1'b0;
    end
  end

  assign led  = r_led;
  assign step = r_step;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed self-checking bench for led_pattern_engine (WIDTH=8, DIV_W=4).
module tb_led_pattern_engine;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       dir;
  logic [3:0] div;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] led;
  logic       step;

  int checks;
  int failures;

  led_pattern_engine #(.WIDTH(8), .DIV_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .div      (div),
    .load     (load),
    .load_val (load_val),
    .led      (led),
    .step     (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge, then return to the falling edge for sampling/driving.
  task automatic next_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 2'b00; dir = 1'b0; div = 4'd0;
    load = 1'b0; load_val = 8'h00;
    #1;
    checks++;
    if (led !== 8'h01 || step !== 1'b0) begin
      failures++;
      $display("FAIL reset_initial led=%h step=%b expected led=01 step=0", led, step);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) next_edge();
    // Asynchronous assert away from any clock edge.
    #2 rst = 1'b1;
    #1;
    checks++;
    if (led !== 8'h01 || step !== 1'b0) begin
      failures++;
      $display("FAIL reset_async led=%h step=%b expected led=01 step=0", led, step);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rotate_left();
    logic [7:0] exp [8];
    exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    for (int i = 0; i < 8; i++) begin
      next_edge();
      checks++;
      if (led !== exp[i] || step !== 1'b1) begin
        failures++;
        $display("FAIL rot_left[%0d] led=%h step=%b expected led=%h step=1",
                 i, led, step, exp[i]);
      end
    end
  endtask

  task automatic test_rotate_right();
    dir = 1'b1;
    next_edge();
    checks++;
    if (led !== 8'h80) begin
      failures++;
      $display("FAIL rot_right_0 led=%h expected 80", led);
    end
    next_edge();
    checks++;
    if (led !== 8'h40) begin
      failures++;
      $display("FAIL rot_right_1 led=%h expected 40", led);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_edge();
      checks++;
      if (led !== 8'h40 || step !== 1'b0) begin
        failures++;
        $display("FAIL en_gap[%0d] led=%h step=%b expected led=40 step=0", i, led, step);
      end
    end
    en = 1'b1;
    next_edge();
    checks++;
    if (led !== 8'h20 || step !== 1'b1) begin
      failures++;
      $display("FAIL en_resume led=%h step=%b expected led=20 step=1", led, step);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] exp [15];
    exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
            8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    load = 1'b1; load_val = 8'h01; dir = 1'b0; mode = 2'b01;
    next_edge();
    load = 1'b0;
    checks++;
    if (led !== 8'h01 || step !== 1'b0) begin
      failures++;
      $display("FAIL bounce_load led=%h step=%b expected led=01 step=0", led, step);
    end
    dir = 1'b1; // ignored by bounce after load
    for (int i = 0; i < 15; i++) begin
      next_edge();
      checks++;
      if (led !== exp[i]) begin
        failures++;
        $display("FAIL bounce[%0d] led=%h expected %h", i, led, exp[i]);
      end
    end
  endtask

  task automatic test_fill();
    logic [7:0] exp [16];
    exp = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE,
            8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};
    load = 1'b1; load_val = 8'h01; mode = 2'b10;
    next_edge();
    load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      next_edge();
      checks++;
      if (led !== exp[i]) begin
        failures++;
        $display("FAIL fill[%0d] led=%h expected %h", i, led, exp[i]);
      end
    end
  endtask

  task automatic test_prescaler();
    load = 1'b1; load_val = 8'h01; mode = 2'b00; dir = 1'b0; div = 4'd3;
    next_edge();
    load = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 3; i++) begin
        next_edge();
        checks++;
        if (step !== 1'b0) begin
          failures++;
          $display("FAIL presc_idle[%0d][%0d] step=%b expected 0", p, i, step);
        end
      end
      next_edge();
      checks++;
      if (step !== 1'b1 || led !== (p == 0 ? 8'h02 : 8'h04)) begin
        failures++;
        $display("FAIL presc_step[%0d] led=%h step=%b expected led=%h step=1",
                 p, led, step, (p == 0 ? 8'h02 : 8'h04));
      end
    end
    // cnt reaches 2, then div drops to 1: the next edge must step.
    repeat (2) next_edge();
    div = 4'd1;
    next_edge();
    checks++;
    if (step !== 1'b1 || led !== 8'h08) begin
      failures++;
      $display("FAIL presc_div_drop led=%h step=%b expected led=08 step=1", led, step);
    end
  endtask

  task automatic test_load_hold();
    div = 4'd0; en = 1'b1; mode = 2'b11;
    load = 1'b1; load_val = 8'hA5;
    next_edge();
    load = 1'b0;
    checks++;
    if (led !== 8'hA5 || step !== 1'b0) begin
      failures++;
      $display("FAIL load_on_tick led=%h step=%b expected led=a5 step=0", led, step);
    end
    div = 4'd1;
    for (int i = 0; i < 4; i++) begin
      next_edge();
      checks++;
      if (led !== 8'hA5 || step !== logic'(i % 2)) begin
        failures++;
        $display("FAIL hold[%0d] led=%h step=%b expected led=a5 step=%0d",
                 i, led, step, i % 2);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_rotate_left();
    test_rotate_right();
    test_bounce();
    test_fill();
    test_prescaler();
    test_load_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
